// File: rtl/int_to_fp16_pipe.sv
// int_to_fp16_pipe: three-stage integer-to-FP16 converter with round-to-nearest-even.
//   S1: sign / absolute value / zero detect
//   S2: leading-one detect and left normalisation
//   S3: round, exponent assembly, overflow handling
// Valid/ready handshake on both sides; one conversion per cycle when unstalled.
// Optional build macro: INT_TO_FP16_SATURATE_EN -- overflow yields the largest
// finite magnitude {sign,15'h7BFF} instead of signed infinity.
module int_to_fp16_pipe #(
  parameter int INT_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] int_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      fp_out,
  output logic             flag_inexact,
  output logic             flag_overflow
);

  // Normalised width: the operand plus 11 zero bits, so mantissa, guard and at
  // least one sticky bit always exist even for narrow inputs. Only the bits
  // below the leading one are kept in the S2 register.
  localparam int NW = INT_W + 11;
  localparam logic [INT_W-1:0] ONE = INT_W'(1);

  // Stage enables: a stage loads when empty or when its successor moves on.
  logic s1_en, s2_en, s3_en;

  logic             s1_valid_q, s2_valid_q, s3_valid_q;
  logic             s1_sign_q, s1_zero_q;
  logic [INT_W-1:0] s1_abs_q;
  logic             s2_sign_q, s2_zero_q;
  logic [5:0]       s2_p_q;
  logic [NW-2:0]    s2_norm_q;
  logic [15:0]      s3_fp_q;
  logic             s3_inx_q, s3_ovf_q;

  assign s3_en    = !s3_valid_q || out_ready;
  assign s2_en    = !s2_valid_q || s3_en;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  // ---------------- S1: sign and magnitude ----------------
  logic             s1_sign_d, s1_zero_d;
  logic [INT_W-1:0] s1_abs_d;

  // Two's-complement negate in INT_W bits; the most-negative value maps to
  // 2^(INT_W-1), which is exactly representable as an unsigned magnitude.
  always_comb begin
    s1_sign_d = (SIGNED != 0) ? int_in[INT_W-1] : 1'b0;
    s1_abs_d  = s1_sign_d ? (~int_in + ONE) : int_in;
    s1_zero_d = (int_in == '0);
  end

  // S1 register: captures a new word whenever the stage is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, so the outputs read 0 after reset.
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_abs_q   <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= s1_sign_d;
        s1_zero_q <= s1_zero_d;
        s1_abs_q  <= s1_abs_d;
      end
    end
  end

  // ---------------- S2: leading-one detect and normalise ----------------
  logic [5:0]    lod_p;
  logic [5:0]    norm_sh;
  logic [NW-2:0] s2_norm_d;

  // Highest set bit wins because later loop iterations override earlier ones.
  always_comb begin
    // NOTE: default first so every path assigns lod_p and no latch is inferred.
    lod_p = '0;
    for (int i = 0; i < INT_W; i++) begin
      if (s1_abs_q[i]) lod_p = 6'(i);
    end
    norm_sh = 6'(INT_W - 1) - lod_p;
    // The leading one itself shifts out of the top; only fraction bits remain.
    s2_norm_d = {s1_abs_q[INT_W-2:0], 11'b0} << norm_sh;
  end

  // S2 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_p_q     <= '0;
      s2_norm_q  <= '0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_q <= s1_sign_q;
        s2_zero_q <= s1_zero_q;
        s2_p_q    <= lod_p;
        s2_norm_q <= s2_norm_d;
      end
    end
  end

  // ---------------- S3: round and pack ----------------
  logic [9:0]  mant;
  logic        guard, sticky, round_up;
  logic [10:0] mant_r;
  logic [6:0]  exp_r;
  logic [15:0] s3_fp_d;
  logic        s3_inx_d, s3_ovf_d;

  // Round-to-nearest-even; a mantissa carry-out bumps the exponent.
  always_comb begin
    mant     = s2_norm_q[NW-2 -: 10];
    guard    = s2_norm_q[NW-12];
    sticky   = |s2_norm_q[NW-13:0];
    round_up = guard && (sticky || mant[0]);
    mant_r   = {1'b0, mant} + {10'b0, round_up};
    exp_r    = 7'(s2_p_q) + 7'd15 + {6'b0, mant_r[10]};
    s3_fp_d  = {s2_sign_q, exp_r[4:0], mant_r[9:0]};
    s3_inx_d = guard | sticky;
    s3_ovf_d = 1'b0;
    if (s2_zero_q) begin
      s3_fp_d  = 16'h0000;
      s3_inx_d = 1'b0;
    end else if (exp_r >= 7'd31) begin
`ifdef INT_TO_FP16_SATURATE_EN
      s3_fp_d  = {s2_sign_q, 15'h7BFF};
`else
      s3_fp_d  = {s2_sign_q, 5'h1F, 10'h000};
`endif
      s3_inx_d = 1'b1;
      s3_ovf_d = 1'b1;
    end
  end

  // S3 register: holds the result stable while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      s3_fp_q    <= '0;
      s3_inx_q   <= 1'b0;
      s3_ovf_q   <= 1'b0;
    end else if (s3_en) begin
      // NOTE: non-blocking assignments keep all stages shifting on the same edge.
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_fp_q  <= s3_fp_d;
        s3_inx_q <= s3_inx_d;
        s3_ovf_q <= s3_ovf_d;
      end
    end
  end

  assign out_valid     = s3_valid_q;
  assign fp_out        = s3_fp_q;
  assign flag_inexact  = s3_inx_q;
  assign flag_overflow = s3_ovf_q;

endmodule
